// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// issues registered stage-start pulses and write-back strobes, and traps stalls in ERROR.
module stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   IF_kick_up,
    input  logic                   Controller_kick_up,
    input  logic                   Controller_memread,
    input  logic                   Controller_memwrite,
    input  logic                   Controller_regwrite,
    input  logic                   Controller_branch,
    input  logic                   EX_done,
    input  logic                   MEM_done,
    output logic                   fetch_start,
    output logic                   ex_start,
    output logic                   mem_start,
    output logic                   wb_en,
    output logic                   pc_update,
    output logic                   pc_branch,
    output logic                   busy,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic                   timeout_err
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_ERROR     = 3'd7
    } state_t;

    // Latched decode controls: {memread, memwrite, regwrite, branch}
    localparam int CTL_MR = 3;
    localparam int CTL_MW = 2;
    localparam int CTL_RW = 1;
    localparam int CTL_BR = 0;

    state_t                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [WAIT_W-1:0]      wait_inc_s;
    logic                   halt_pend_q, halt_pend_d;
    logic [3:0]             ctl_q, ctl_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   wait_lim_s;
    logic                   active_s;

    logic fetch_start_q, fetch_start_d;
    logic ex_start_q, ex_start_d;
    logic mem_start_q, mem_start_d;
    logic wb_en_q, wb_en_d;
    logic pc_update_q, pc_update_d;
    logic pc_branch_q, pc_branch_d;
    logic busy_q, busy_d;
    logic timeout_err_q, timeout_err_d;

    // Next-state, wait counter, halt/control latches and retire counter
    always_comb begin
        state_d    = state_q;
        wait_inc_s = wait_q;
        ctl_d      = ctl_q;
        count_d    = count_q;
        wait_lim_s = (wait_q == WAIT_LIMIT);
        active_s   = (state_q != ST_IDLE) && (state_q != ST_ERROR);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (IF_kick_up) begin
                    state_d = ST_DECODE;
                end else if (wait_lim_s) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_inc_s = wait_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (Controller_kick_up) begin
                    ctl_d   = {Controller_memread, Controller_memwrite,
                               Controller_regwrite, Controller_branch};
                    state_d = ST_EXECUTE;
                end else if (wait_lim_s) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_inc_s = wait_q + WAIT_W'(1);
                end
            end
            ST_EXECUTE: begin
                if (EX_done) begin
                    if (ctl_q[CTL_MR] || ctl_q[CTL_MW]) begin
                        state_d = ST_MEMORY;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (wait_lim_s) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_inc_s = wait_q + WAIT_W'(1);
                end
            end
            ST_MEMORY: begin
                if (MEM_done) begin
                    state_d = ST_WRITEBACK;
                end else if (wait_lim_s) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_inc_s = wait_q + WAIT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                count_d = count_q + COUNT_WIDTH'(1);
                if (halt_pend_q || halt) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any state change starts a fresh wait window
        if (state_d != state_q) begin
            wait_d = '0;
        end else begin
            wait_d = wait_inc_s;
        end

        if ((state_d == ST_IDLE) || (state_d == ST_ERROR)) begin
            halt_pend_d = 1'b0;
        end else if (halt && active_s) begin
            halt_pend_d = 1'b1;
        end else begin
            halt_pend_d = halt_pend_q;
        end
    end

    // Registered output values derived from the upcoming state
    always_comb begin
        fetch_start_d = (state_d == ST_FETCH)   && (state_q != ST_FETCH);
        ex_start_d    = (state_d == ST_EXECUTE) && (state_q != ST_EXECUTE);
        mem_start_d   = (state_d == ST_MEMORY)  && (state_q != ST_MEMORY);
        pc_update_d   = (state_d == ST_WRITEBACK);
        wb_en_d       = (state_d == ST_WRITEBACK) && ctl_d[CTL_RW];
        pc_branch_d   = (state_d == ST_WRITEBACK) && ctl_d[CTL_BR];
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_ERROR);
        timeout_err_d = timeout_err_q || (state_d == ST_ERROR);
    end

    // State, counters and latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            halt_pend_q <= 1'b0;
            ctl_q       <= 4'd0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            halt_pend_q <= halt_pend_d;
            ctl_q       <= ctl_d;
            count_q     <= count_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_start_q <= 1'b0;
            ex_start_q    <= 1'b0;
            mem_start_q   <= 1'b0;
            wb_en_q       <= 1'b0;
            pc_update_q   <= 1'b0;
            pc_branch_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            fetch_start_q <= fetch_start_d;
            ex_start_q    <= ex_start_d;
            mem_start_q   <= mem_start_d;
            wb_en_q       <= wb_en_d;
            pc_update_q   <= pc_update_d;
            pc_branch_q   <= pc_branch_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign fetch_start   = fetch_start_q;
    assign ex_start      = ex_start_q;
    assign mem_start     = mem_start_q;
    assign wb_en         = wb_en_q;
    assign pc_update     = pc_update_q;
    assign pc_branch     = pc_branch_q;
    assign busy          = busy_q;
    assign state         = state_q;
    assign retired_count = count_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: vector table for the instruction flows,
// hand sequences for timeout, counter wrap and mid-instruction reset.
module tb_stage_sequencer;

    localparam int TO = 16;
    localparam int CW = 4;

    // Input vector bit order: {start, halt, IF, CTL, mr, mw, rw, br, EX, MEM}
    localparam logic [9:0] I_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] I_START = 10'b10_0000_0000;
    localparam logic [9:0] I_HALT  = 10'b01_0000_0000;
    localparam logic [9:0] I_IFK   = 10'b00_1000_0000;
    localparam logic [9:0] I_CTK   = 10'b00_0100_0000;
    localparam logic [9:0] I_MR    = 10'b00_0010_0000;
    localparam logic [9:0] I_MW    = 10'b00_0001_0000;
    localparam logic [9:0] I_RW    = 10'b00_0000_1000;
    localparam logic [9:0] I_BR    = 10'b00_0000_0100;
    localparam logic [9:0] I_EXD   = 10'b00_0000_0010;
    localparam logic [9:0] I_MEMD  = 10'b00_0000_0001;

    // Flag order: {fetch_start, ex_start, mem_start, wb_en, pc_update, pc_branch}
    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_FS   = 6'b100000;
    localparam logic [5:0] F_ES   = 6'b010000;
    localparam logic [5:0] F_MS   = 6'b001000;
    localparam logic [5:0] F_WB   = 6'b000100;
    localparam logic [5:0] F_PU   = 6'b000010;
    localparam logic [5:0] F_PB   = 6'b000001;

    logic clk = 1'b0;
    logic reset;
    logic start, halt, IF_kick_up, Controller_kick_up;
    logic Controller_memread, Controller_memwrite, Controller_regwrite, Controller_branch;
    logic EX_done, MEM_done;
    logic fetch_start, ex_start, mem_start, wb_en, pc_update, pc_branch, busy, timeout_err;
    logic [2:0] state;
    logic [CW-1:0] retired_count;
    logic [14:0] act;

    typedef struct {
        logic [9:0]  in;
        logic [14:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [14:0] sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  cnt_m;

    stage_sequencer #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .halt                (halt),
        .IF_kick_up          (IF_kick_up),
        .Controller_kick_up  (Controller_kick_up),
        .Controller_memread  (Controller_memread),
        .Controller_memwrite (Controller_memwrite),
        .Controller_regwrite (Controller_regwrite),
        .Controller_branch   (Controller_branch),
        .EX_done             (EX_done),
        .MEM_done            (MEM_done),
        .fetch_start         (fetch_start),
        .ex_start            (ex_start),
        .mem_start           (mem_start),
        .wb_en               (wb_en),
        .pc_update           (pc_update),
        .pc_branch           (pc_branch),
        .busy                (busy),
        .state               (state),
        .retired_count       (retired_count),
        .timeout_err         (timeout_err)
    );

    always #5 clk = ~clk;

    assign act = {fetch_start, ex_start, mem_start, wb_en, pc_update, pc_branch,
                  busy, state, timeout_err, retired_count};

    function automatic logic [14:0] mk(input logic [2:0] st, input logic [5:0] fl,
                                       input logic [3:0] c);
        logic busy_v;
        logic err_v;
        busy_v = (st != 3'd0) && (st != 3'd7);
        err_v  = (st == 3'd7);
        return {fl, busy_v, st, err_v, c};
    endfunction

    task automatic drive(input logic [9:0] in);
        {start, halt, IF_kick_up, Controller_kick_up, Controller_memread,
         Controller_memwrite, Controller_regwrite, Controller_branch,
         EX_done, MEM_done} = in;
    endtask

    task automatic check(input string nm, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got fs/es/ms/wb/pu/pb/busy/st/err/cnt=%b required %b", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic [9:0] in, input logic [14:0] exp);
        @(negedge clk);
        drive(in);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        check(nm, sb.pop_front());
    endtask

    task automatic add(input logic [9:0] in, input logic [2:0] st, input logic [5:0] fl,
                       input logic [3:0] c);
        vec_t v;
        v.in  = in;
        v.exp = mk(st, fl, c);
        tbl.push_back(v);
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb.push_back(mk(3'd0, F_NONE, 4'd0));
        check(nm, sb.pop_front());
        @(negedge clk);
        drive(I_NONE);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(I_NONE);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", mk(3'd0, F_NONE, 4'd0));
        @(negedge clk);
        reset = 1'b1;

        // ALU, load, store, branch+dual-mem, halt in EXECUTE, halt in WRITEBACK
        add(I_NONE,               3'd0, F_NONE,      4'd0);
        add(I_HALT,               3'd0, F_NONE,      4'd0);
        add(I_EXD,                3'd0, F_NONE,      4'd0);
        add(I_START,              3'd1, F_FS,        4'd0);
        add(I_START | I_CTK,      3'd1, F_NONE,      4'd0);
        add(I_IFK,                3'd2, F_NONE,      4'd0);
        add(I_CTK | I_RW,         3'd3, F_ES,        4'd0);
        add(I_EXD,                3'd5, F_WB | F_PU, 4'd0);
        add(I_NONE,               3'd1, F_FS,        4'd1);
        add(I_IFK,                3'd2, F_NONE,      4'd1);
        add(I_CTK | I_MR | I_RW,  3'd3, F_ES,        4'd1);
        add(I_EXD,                3'd4, F_MS,        4'd1);
        add(I_NONE,               3'd4, F_NONE,      4'd1);
        add(I_MEMD,               3'd5, F_WB | F_PU, 4'd1);
        add(I_NONE,               3'd1, F_FS,        4'd2);
        add(I_IFK,                3'd2, F_NONE,      4'd2);
        add(I_CTK | I_MW,         3'd3, F_ES,        4'd2);
        add(I_EXD,                3'd4, F_MS,        4'd2);
        add(I_MEMD,               3'd5, F_PU,        4'd2);
        add(I_NONE,               3'd1, F_FS,        4'd3);
        add(I_IFK,                3'd2, F_NONE,      4'd3);
        add(I_CTK | I_BR | I_MR | I_MW, 3'd3, F_ES,  4'd3);
        add(I_EXD,                3'd4, F_MS,        4'd3);
        add(I_MEMD,               3'd5, F_PU | F_PB, 4'd3);
        add(I_NONE,               3'd1, F_FS,        4'd4);
        add(I_IFK,                3'd2, F_NONE,      4'd4);
        add(I_CTK | I_RW,         3'd3, F_ES,        4'd4);
        add(I_HALT,               3'd3, F_NONE,      4'd4);
        add(I_EXD,                3'd5, F_WB | F_PU, 4'd4);
        add(I_NONE,               3'd0, F_NONE,      4'd5);
        add(I_NONE,               3'd0, F_NONE,      4'd5);
        add(I_START,              3'd1, F_FS,        4'd5);
        add(I_IFK,                3'd2, F_NONE,      4'd5);
        add(I_CTK,                3'd3, F_ES,        4'd5);
        add(I_MEMD | I_IFK,       3'd3, F_NONE,      4'd5);
        add(I_EXD,                3'd5, F_PU,        4'd5);
        add(I_HALT,               3'd0, F_NONE,      4'd6);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
        end
        cnt_m = 4'd6;

        // EX_done on the last allowed wait cycle wins over the timeout
        step("late_start", I_START, mk(3'd1, F_FS, cnt_m));
        step("late_if",    I_IFK,   mk(3'd2, F_NONE, cnt_m));
        step("late_ctl",   I_CTK,   mk(3'd3, F_ES, cnt_m));
        for (int i = 1; i < TO; i++) begin
            step($sformatf("late_wait%0d", i), I_NONE, mk(3'd3, F_NONE, cnt_m));
        end
        step("late_done", I_EXD, mk(3'd5, F_PU, cnt_m));
        cnt_m = cnt_m + 4'd1;
        step("late_refetch", I_NONE, mk(3'd1, F_FS, cnt_m));

        // Withheld EX_done traps in ERROR
        step("to_if",  I_IFK, mk(3'd2, F_NONE, cnt_m));
        step("to_ctl", I_CTK, mk(3'd3, F_ES, cnt_m));
        for (int i = 1; i < TO; i++) begin
            step($sformatf("to_wait%0d", i), I_NONE, mk(3'd3, F_NONE, cnt_m));
        end
        step("to_error",      I_NONE,  mk(3'd7, F_NONE, cnt_m));
        step("to_start_ign",  I_START, mk(3'd7, F_NONE, cnt_m));
        step("to_done_ign",   I_EXD,   mk(3'd7, F_NONE, cnt_m));
        async_reset("to_reset");
        step("to_post_reset", I_NONE,  mk(3'd0, F_NONE, 4'd0));

        // Retirement counter wraps at COUNT_WIDTH bits
        cnt_m = 4'd0;
        step("wrap_start", I_START, mk(3'd1, F_FS, cnt_m));
        for (int k = 0; k < 16; k++) begin
            step($sformatf("wrap_if%0d", k),  I_IFK,         mk(3'd2, F_NONE, cnt_m));
            step($sformatf("wrap_ctl%0d", k), I_CTK | I_RW,  mk(3'd3, F_ES, cnt_m));
            step($sformatf("wrap_ex%0d", k),  I_EXD,         mk(3'd5, F_WB | F_PU, cnt_m));
            cnt_m = cnt_m + 4'd1;
            step($sformatf("wrap_ret%0d", k), I_NONE,        mk(3'd1, F_FS, cnt_m));
        end

        // Reset while in MEMORY abandons the instruction
        step("mr_if",  I_IFK,        mk(3'd2, F_NONE, cnt_m));
        step("mr_ctl", I_CTK | I_MR, mk(3'd3, F_ES, cnt_m));
        step("mr_ex",  I_EXD,        mk(3'd4, F_MS, cnt_m));
        async_reset("mr_reset");
        step("mr_idle0", I_MEMD,  mk(3'd0, F_NONE, 4'd0));
        step("mr_idle1", I_NONE,  mk(3'd0, F_NONE, 4'd0));
        step("mr_start", I_START, mk(3'd1, F_FS, 4'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
